// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: internal pointers, occupancy count, programmable flags, sticky errors, flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; the default is registered-read mode.
module sync_fifo_param #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 5,
  parameter int ALMOST_FULL_TH  = 28,
  parameter int ALMOST_EMPTY_TH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  writeEnable,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  readEnable,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  rdValid,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic                  almostEmpty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                  PW      = ADDR_WIDTH + 1;
  localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_C    = PW'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_C    = PW'(ALMOST_EMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [ADDR_WIDTH:0] wptr, rptr;
  logic [ADDR_WIDTH:0] wptr_nx, rptr_nx, count_nx;
  logic                wr_acc, rd_acc;
  logic                mem_we, rd_load, rd_bypass, rdv_nx;

`ifdef SYNC_FIFO_FWFT_EN
  logic mem_has, stage_free;
  // The output stage is the head of the FIFO; empty simply means the stage holds nothing.
  assign empty = ~rdValid;
`endif

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    wr_acc     = writeEnable & ~full;
`ifdef SYNC_FIFO_FWFT_EN
    rd_acc     = readEnable & rdValid;
    mem_has    = (wptr != rptr);
    stage_free = ~rdValid | readEnable;
    // Refill the stage from the array first; a write bypasses straight in only when the array is empty.
    rd_load    = ~flush & stage_free & mem_has;
    rd_bypass  = ~flush & stage_free & ~mem_has & wr_acc;
    mem_we     = ~flush & wr_acc & ~rd_bypass;
    rdv_nx     = ~flush & ((rdValid & ~readEnable) | rd_load | rd_bypass);
`else
    rd_acc     = readEnable & ~empty;
    rd_load    = ~flush & rd_acc;
    rd_bypass  = 1'b0;
    mem_we     = ~flush & wr_acc;
    rdv_nx     = rd_load;
`endif
    if (flush) begin
      wptr_nx  = '0;
      rptr_nx  = '0;
      count_nx = '0;
    end else begin
      wptr_nx  = wptr + PW'(mem_we);
      rptr_nx  = rptr + PW'(rd_load);
      count_nx = count + PW'(wr_acc) - PW'(rd_acc);
    end
  end

  // NOTE: registers use non-blocking assignments so each one samples the pre-edge state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      rdValid     <= 1'b0;
      full        <= 1'b0;
      almostFull  <= 1'b0;
      almostEmpty <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
      empty       <= 1'b1;
`endif
    end else begin
      wptr        <= wptr_nx;
      rptr        <= rptr_nx;
      count       <= count_nx;
      rdValid     <= rdv_nx;
      // Flags come from the post-edge count so they never lag the occupancy.
      full        <= (count_nx == DEPTH_C);
      almostFull  <= (count_nx >= AF_C);
      almostEmpty <= (count_nx <= AE_C);
      overflow    <= overflow | (~flush & writeEnable & full);
      underflow   <= underflow | (~flush & readEnable & empty);
`ifndef SYNC_FIFO_FWFT_EN
      empty       <= (count_nx == '0);
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        rd <= '0;
    else if (rd_load)   rd <= mem[rptr[ADDR_WIDTH-1:0]];
    else if (rd_bypass) rd <= wd;
  end

  // NOTE: the storage array has no reset; pointers and count alone decide which words are live.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr[ADDR_WIDTH-1:0]] <= wd;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue-based occupancy model.
// Follows SYNC_FIFO_FWFT_EN the same way the design does.
module tb_sync_fifo_param;

  localparam int DW = 32, AW = 5, DEPTH = 32, AF = 28, AE = 4;

  logic          clk = 1'b0, resetn = 1'b0, flush = 1'b0;
  logic          writeEnable = 1'b0, readEnable = 1'b0;
  logic [DW-1:0] wd = '0, rd;
  logic          rdValid, full, empty, almostFull, almostEmpty, overflow, underflow;
  logic [AW:0]   count;

  sync_fifo_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_TH(AF), .ALMOST_EMPTY_TH(AE)
  ) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .writeEnable(writeEnable), .wd(wd),
    .readEnable(readEnable), .rd(rd), .rdValid(rdValid), .full(full), .empty(empty),
    .almostFull(almostFull), .almostEmpty(almostEmpty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: the queue holds every word the FIFO owns, head at index 0.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  bit            m_rdv, m_ovf, m_unf;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      m_rd = '0; m_rdv = 0; m_ovf = 0; m_unf = 0;
    end else if (flush) begin
      q.delete();
      m_rdv = 0;
    end else begin
      bit w_ok, r_ok;
      w_ok = writeEnable && (q.size() < DEPTH);
      r_ok = readEnable && (q.size() > 0);
      if (writeEnable && !w_ok) m_ovf = 1;
      if (readEnable && !r_ok)  m_unf = 1;
`ifdef SYNC_FIFO_FWFT_EN
      if (r_ok) void'(q.pop_front());
      if (w_ok) q.push_back(wd);
      m_rdv = (q.size() > 0);
      if (m_rdv) m_rd = q[0];
`else
      if (r_ok) m_rd = q.pop_front();
      m_rdv = r_ok;
      if (w_ok) q.push_back(wd);
`endif
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      check("count",       count,       q.size());
      check("full",        full,        q.size() == DEPTH);
      check("empty",       empty,       q.size() == 0);
      check("almostFull",  almostFull,  q.size() >= AF);
      check("almostEmpty", almostEmpty, q.size() <= AE);
      check("rdValid",     rdValid,     m_rdv);
      check("rd",          rd,          m_rd);
      check("overflow",    overflow,    m_ovf);
      check("underflow",   underflow,   m_unf);
    end
  end

  // Inputs change 1 time unit after a rising edge; the task returns at the same point of the next cycle.
  task automatic drive(input bit f, input bit we, input logic [DW-1:0] d, input bit re);
    flush = f; writeEnable = we; wd = d; readEnable = re;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    flush = 0; writeEnable = 0; readEnable = 0; wd = '0;
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;
  endtask

  initial begin
    int wb[6] = '{85, 20, 60, 95, 10, 50};
    int rb[6] = '{30, 85, 60, 40, 90, 50};

    #12;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_almostEmpty", almostEmpty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_almostFull", almostFull, 1'b0);
    check("rst_rdValid", rdValid, 1'b0);
    @(posedge clk); #1;
    resetn = 1;

    // Fill 1..32, then one write too many.
    for (int i = 1; i <= DEPTH; i++) begin
      drive(0, 1, DW'(i), 0);
      if (i == AF - 1) check("af_below", almostFull, 1'b0);
      if (i == AF)     check("af_at", almostFull, 1'b1);
    end
    check("fill_count", count, 32);
    check("fill_full", full, 1'b1);
    drive(0, 1, 33, 0);
    check("ovf_set", overflow, 1'b1);
    check("ovf_count", count, 32);

    // Drain in order, then one read too many.
    for (int i = 1; i <= DEPTH; i++) begin
      drive(0, 0, 0, 1);
`ifndef SYNC_FIFO_FWFT_EN
      check("drain_rd", rd, i);
      check("drain_valid", rdValid, 1'b1);
`endif
    end
    check("drain_empty", empty, 1'b1);
    drive(0, 0, 0, 1);
    check("unf_set", underflow, 1'b1);
    check("unf_rd_hold", rd, 32);

    // Simultaneous read+write across the pointer wrap.
    do_reset();
    for (int i = 0; i < 5; i++) drive(0, 1, DW'(100 + i), 0);
    for (int i = 0; i < 40; i++) drive(0, 1, $urandom, 1);
    check("wrap_count", count, 5);
    check("wrap_ovf", overflow, 1'b0);
    check("wrap_unf", underflow, 1'b0);

    // Full boundary: read and write together while full.
    for (int i = 0; i < DEPTH - 5; i++) drive(0, 1, $urandom, 0);
    check("coll_full", full, 1'b1);
    drive(0, 1, 32'hDEAD_BEEF, 1);
    check("coll_count", count, 31);
    check("coll_ovf", overflow, 1'b1);

    // Flush with a write pending: nothing stored, flags return to empty.
    do_reset();
    for (int i = 0; i < 10; i++) drive(0, 1, $urandom, 0);
    drive(1, 1, 32'h1234_5678, 0);
    check("flush_count", count, 0);
    check("flush_empty", empty, 1'b1);
    drive(0, 0, 0, 1);
    check("flush_no_write", underflow, 1'b1);

`ifdef SYNC_FIFO_FWFT_EN
    do_reset();
    drive(0, 1, 32'hA5, 0);
    check("fwft_rd", rd, 32'hA5);
    check("fwft_valid", rdValid, 1'b1);
    drive(0, 1, 32'hB1, 0);
    drive(0, 1, 32'hB2, 0);
    drive(0, 0, 0, 1);
    check("fwft_pop1_rd", rd, 32'hB1);
    check("fwft_pop1_valid", rdValid, 1'b1);
    drive(0, 0, 0, 1);
    check("fwft_pop2_rd", rd, 32'hB2);
    check("fwft_pop2_valid", rdValid, 1'b1);
    drive(0, 0, 0, 1);
    check("fwft_pop3_empty", empty, 1'b1);
`endif

    // Random traffic with shifting bias so the FIFO visits full and empty.
    do_reset();
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < 250; c++) begin
        drive($urandom_range(0, 63) == 0,
              $urandom_range(0, 99) < wb[s],
              $urandom,
              $urandom_range(0, 99) < rb[s]);
      end
    end

    // Asynchronous reset in the middle of a burst takes effect before any edge.
    for (int i = 0; i < 6; i++) drive(0, 1, $urandom, i[0]);
    writeEnable = 1;
    resetn = 0;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1'b1);
    check("arst_full", full, 1'b0);
    check("arst_rdValid", rdValid, 1'b0);
    check("arst_rd", rd, 0);
    check("arst_ovf", overflow, 1'b0);
    check("arst_unf", underflow, 1'b0);
    @(posedge clk); #1;
    resetn = 1;
    drive(0, 1, 32'h77, 0);
    check("post_rst_count", count, 1);
    drive(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the dual-port RAM FIFO.
- Pointers are generated internally, so the user does not drive wptr/rptr.
- Provides full/empty, programmable almost-full/almost-empty flags, an occupancy count, sticky error flags and a synchronous flush.
- Serves as the same-clock-domain buffer between a producer and a consumer where the asynchronous FIFO is not needed.

Parameters:
- DATA_WIDTH, 32, width of the data word.
- ADDR_WIDTH, 5, log2 of depth; DEPTH = 2**ADDR_WIDTH (32).
- ALMOST_FULL_TH, 28, almostFull asserts when count >= this value.
- ALMOST_EMPTY_TH, 4, almostEmpty asserts when count <= this value.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of contents and pointers.
- writeEnable  input  1  write request.
- wd  input  DATA_WIDTH  write data.
- readEnable  input  1  read request (pop).
- rd  output  DATA_WIDTH  read data, registered.
- rdValid  output  1  rd holds a freshly popped word (standard mode) or the head word (FWFT).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almostFull  output  1  count >= ALMOST_FULL_TH.
- almostEmpty  output  1  count <= ALMOST_EMPTY_TH.
- count  output  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- overflow  output  1  sticky; set on a write attempted while full.
- underflow  output  1  sticky; set on a read attempted while empty.

Behaviour:
Reset:
- resetn low clears, asynchronously: pointers, count, rd, rdValid, overflow and underflow.
- After reset: empty=1, almostEmpty=1, full=0, almostFull=0.
- Memory contents are not reset.
- Reset asserted mid-operation discards all data immediately; the first edge after release behaves as a fresh FIFO.

Pointers:
- wptr and rptr are ADDR_WIDTH+1 bits. The extra MSB is the wrap bit.
- full: address bits equal and MSBs differ.
- empty: the pointers are equal.
- count = wptr - rptr, modulo 2**(ADDR_WIDTH+1), registered alongside the pointers.

Write acceptance:
- Accepted = writeEnable & ~full, evaluated on pre-edge state.
- On acceptance, wd is stored at wptr and wptr increments.
- A write while full is dropped and sets overflow. This holds even when a read is accepted in the same cycle (no write-through when full).

Read acceptance:
- Accepted = readEnable & ~empty, evaluated on pre-edge state.
- On acceptance, rd loads mem[rptr] at that edge and rptr increments.
- rdValid is high for the following cycle only.
- rd holds its value until the next accepted read.
- A read while empty is ignored and sets underflow. A write in the same cycle does not bypass to rd.

Simultaneous accepted read and write:
- count unchanged; both pointers advance.
- Must hold across the pointer wrap from DEPTH-1 to 0.

Flush:
- Synchronous. Sets wptr = rptr = 0, count = 0, rdValid = 0.
- Takes priority over reads and writes in the same cycle.
- Does not clear overflow or underflow, and leaves rd unchanged.

Flags:
- All flags are registered and derived from the post-edge count, with no extra cycle of lag.
- overflow and underflow clear only on resetn.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - An output stage holds the head word. rdValid = head word present; empty = ~rdValid.
  - A write into an empty FIFO is visible on rd with rdValid=1 after the next edge (1-cycle write-to-visible latency).
  - readEnable with rdValid=1 pops the head at the edge; the next word, if any, appears on rd at that same edge with no bubble.
  - count includes the word in the output stage; full still means count == DEPTH.
- Undefined: standard registered-read mode as described above.

Test Plan:
- Reset and fill: reset, then write 1..32 on consecutive cycles -> count=32, full=1 after the 32nd edge, almostFull from count 28. A 33rd write sets overflow=1 and count stays 32.
- Drain: read 32 times -> rd = 1..32 in order, each valid the cycle after its readEnable; empty=1 after the last read. An extra read sets underflow=1 and rd holds 32.
- Wrap with simultaneous access: prefill 5 words, then 40 cycles of simultaneous read+write -> count stays 5, data order preserved across pointer wrap, no flag errors.
- Full-boundary collision: with full=1, assert read and write together -> read accepted, write dropped, overflow=1, count=31.
- Flush and reset: flush with 10 words and writeEnable=1 -> count=0, empty=1, no write stored. Pulse resetn low mid-burst -> all outputs at reset values immediately (before the next clk edge).
- FWFT build: write 0xA5 into an empty FIFO -> rd=0xA5 and rdValid=1 one edge later. Pop on back-to-back reads of 3 words -> no idle cycle between words.
